// File: rtl/seq_mult_pkg.sv
// rtl/seq_mult_pkg.sv - shared types and constants for the shift-add multiplier
package seq_mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 4;
  localparam int PROD_W    = 2 * DEF_WIDTH;

endpackage

// File: rtl/seq_mult_fsm.sv
// rtl/seq_mult_fsm.sv - sequencing FSM and iteration counter for the multiplier
module seq_mult_fsm
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic load,
  output logic shift,
  output logic finish,
  output logic calc,
  output logic busy,
  output logic done
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // State and counter registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, counter update and datapath strobes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    shift   = 1'b0;
    finish  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        shift = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          finish  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign calc = (state_q == ST_CALC);
  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);

endmodule

// File: rtl/seq_mult_ctrl.sv
// rtl/seq_mult_ctrl.sv - shift-add sequential multiplier controller with datapath registers
module seq_mult_ctrl
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mult_start,
  input  logic [WIDTH-1:0]   mult_a,
  input  logic [WIDTH-1:0]   mult_b,
  output logic               mult_busy,
  output logic               mult_done,
  output logic [2*WIDTH-1:0] mult_product,
  output logic               mux_sel
);

  logic load, shift, finish, calc;

  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mq_q, mq_d;
  logic [WIDTH:0]     acc_q, acc_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;

  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   operand;

  seq_mult_fsm #(.WIDTH(WIDTH)) u_fsm (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (mult_start),
    .load   (load),
    .shift  (shift),
    .finish (finish),
    .calc   (calc),
    .busy   (mult_busy),
    .done   (mult_done)
  );

  // The multiplier LSB picks the add operand, but only while iterating.
  assign mux_sel = calc & mq_q[0];
  assign operand = mux_sel ? mcand_q : '0;
  // Accumulator is one bit wider so the carry out of the add survives the shift.
  assign sum     = acc_q + {1'b0, operand};

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand_q <= '0;
      mq_q    <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
    end else begin
      mcand_q <= mcand_d;
      mq_q    <= mq_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
    end
  end

  // Operand capture, add-shift step and product load on the final iteration.
  always_comb begin
    mcand_d = mcand_q;
    mq_d    = mq_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    if (load) begin
      mcand_d = mult_a;
      mq_d    = mult_b;
      acc_d   = '0;
    end else if (shift) begin
      acc_d = {1'b0, sum[WIDTH:1]};
      mq_d  = {sum[0], mq_q[WIDTH-1:1]};
      if (finish) begin
        prod_d = {sum[WIDTH:1], sum[0], mq_q[WIDTH-1:1]};
      end
    end
  end

  assign mult_product = prod_q;

endmodule
